mem_port_arbiter: RTL and testbench

- Shares the single-port data/instruction memory between the instruction-fetch (IF) and data-memory (DM) requesters.
- Drives the select input of the existing 32-bit 2:1 address mux through `mem_sel` (1 = DM address, 0 = IF address).
- Sequences each access: issue, fixed-latency wait, capture, acknowledge.
- Arbitrates simultaneous requests round-robin.

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data memory. Each access is sequenced as issue, fixed-latency wait, capture, ack.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  output logic        dm_ack,
  output logic        mem_sel,
  output logic        mem_en,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        busy
);

  // Handshake: a requester raises req and holds it (with address, dm_we and write
  // data) stable until it sees its one-cycle ack, then drops req the cycle after.
  // Any req seen high while the FSM is IDLE starts a new access.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;    // 1 = DM side owns the memory
  logic        last_q, last_d;  // side granted most recently, 1 = DM
  logic        wr_q, wr_d;      // current access is a DM write
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    if_ack  = 1'b0;
    dm_ack  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // With both requesting, the side not granted last time wins.
        if (if_req || dm_req) begin
          if (if_req && dm_req) begin
            sel_d  = ~last_q;
            last_d = ~last_q;
          end else begin
            sel_d  = dm_req;
            last_d = dm_req;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en  = 1'b1;
        mem_we  = sel_q & dm_we;
        wr_d    = sel_q & dm_we;
        cnt_d   = 4'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if_ack  = ~sel_q;
        dm_ack  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_sel = sel_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, IF read, DM write, round-robin
// alternation, reset abort, and a MEM_LAT=1 build.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        if_req, dm_req, dm_we;
  logic        if_ack, dm_ack, mem_sel, mem_en, mem_we, busy;
  logic [31:0] mem_rdata, rdata;

  logic        if_req1, dm_req1, dm_we1;
  logic        if_ack1, dm_ack1, mem_sel1, mem_en1, mem_we1, busy1;
  logic [31:0] mem_rdata1, rdata1;

  int total = 0;
  int bad   = 0;
  int cyc;

  // Expected grant order, 1 = DM, 0 = IF.
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .rdata(rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_ack(if_ack1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_ack(dm_ack1),
    .mem_sel(mem_sel1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_rdata(mem_rdata1), .rdata(rdata1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy) return;
      tick();
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},   32'(mem_en),  32'd0);
    check({tag, "_we"},   32'(mem_we),  32'd0);
    check({tag, "_sel"},  32'(mem_sel), 32'd0);
    check({tag, "_ack"},  32'({if_ack, dm_ack}), 32'd0);
    check({tag, "_rd"},   rdata,        32'd0);
    check({tag, "_busy"}, 32'(busy),    32'd0);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; mem_rdata = 32'h0BADF00D;
    if_req1 = 1'b0; dm_req1 = 1'b0; dm_we1 = 1'b0; mem_rdata1 = 32'h0;

    // Reset held two cycles with both requests high.
    tick(); check_reset_outputs("rst1");
    tick(); check_reset_outputs("rst2");
    rst = 1'b0;                               // cycle 0
    tick();                                   // cycle 1
    check("rst_first_grant_sel", 32'(mem_sel), 32'd1);
    check("rst_first_grant_en",  32'(mem_en),  32'd1);
    if_req = 1'b0;
    tick(); tick(); tick();                   // cycle 4
    check("rst_dm_ack", 32'(dm_ack), 32'd1);
    check("rst_dm_rdata", rdata, 32'h0BADF00D);
    dm_req = 1'b0;
    wait_idle();

    // IF read, MEM_LAT=2.
    mem_rdata = 32'hDEADBEEF;
    if_req = 1'b1;                            // cycle 0
    check("ifr_busy_c0", 32'(busy), 32'd0);
    tick();                                   // cycle 1
    check("ifr_en_c1",  32'(mem_en),  32'd1);
    check("ifr_sel_c1", 32'(mem_sel), 32'd0);
    check("ifr_we_c1",  32'(mem_we),  32'd0);
    check("ifr_busy_c1", 32'(busy),   32'd1);
    tick();                                   // cycle 2
    check("ifr_en_c2", 32'(mem_en), 32'd0);
    check("ifr_busy_c2", 32'(busy), 32'd1);
    tick();                                   // cycle 3
    check("ifr_ack_c3", 32'(if_ack), 32'd0);
    check("ifr_busy_c3", 32'(busy), 32'd1);
    tick();                                   // cycle 4
    check("ifr_ack_c4", 32'(if_ack), 32'd1);
    check("ifr_dmack_c4", 32'(dm_ack), 32'd0);
    check("ifr_rdata_c4", rdata, 32'hDEADBEEF);
    check("ifr_busy_c4", 32'(busy), 32'd1);
    if_req = 1'b0;
    tick();                                   // cycle 5
    check("ifr_ack_c5", 32'(if_ack), 32'd0);
    check("ifr_busy_c5", 32'(busy), 32'd0);

    // Preload rdata, then a DM write must leave it alone.
    mem_rdata = 32'h12345678;
    if_req = 1'b1;
    repeat (4) tick();
    if_req = 1'b0;
    wait_idle();
    check("preload_rdata", rdata, 32'h12345678);
    mem_rdata = 32'hFFFFFFFF;
    dm_req = 1'b1; dm_we = 1'b1;              // cycle 0
    tick();                                   // cycle 1
    check("dmw_we_c1",  32'(mem_we),  32'd1);
    check("dmw_sel_c1", 32'(mem_sel), 32'd1);
    check("dmw_en_c1",  32'(mem_en),  32'd1);
    tick();                                   // cycle 2
    check("dmw_we_c2",  32'(mem_we),  32'd0);
    check("dmw_sel_c2", 32'(mem_sel), 32'd1);
    tick(); tick();                           // cycle 4
    check("dmw_ack_c4", 32'(dm_ack), 32'd1);
    check("dmw_rdata",  rdata, 32'h12345678);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();                                   // cycle 5, IDLE keeps last side
    check("dmw_sel_idle", 32'(mem_sel), 32'd1);

    // Round-robin after reset: D, I, D, I with a 5-cycle period.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rdata = 32'h11112222;
    if_req = 1'b1; dm_req = 1'b1;             // cycle 0
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    cyc = 0;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      tick();
      cyc++;
      if (if_ack || dm_ack) begin
        logic [0:0] want;
        int         n;
        n = 4 - exp_q.size();
        want = exp_q.pop_front();
        check("rr_both_ack", 32'(if_ack & dm_ack), 32'd0);
        check("rr_side", 32'(dm_ack), 32'(want));
        check("rr_cycle", 32'(cyc), 32'(4 + 5 * n));
        if (exp_q.size() == 0) begin
          if_req = 1'b0; dm_req = 1'b0;
        end
      end
      if (cyc == 6) begin
        check("rr_if_issue_en",  32'(mem_en),  32'd1);
        check("rr_if_issue_sel", 32'(mem_sel), 32'd0);
      end
    end
    check("rr_left", 32'(exp_q.size()), 32'd0);
    if_req = 1'b0; dm_req = 1'b0;
    wait_idle();

    // Reset during the second WAIT cycle of an IF read aborts it.
    mem_rdata = 32'hCAFEF00D;
    if_req = 1'b1;                            // cycle 0
    tick(); tick(); tick();                   // cycle 3, second WAIT
    rst = 1'b1;
    tick();                                   // cycle 4
    rst = 1'b0;
    check("abort_ack", 32'(if_ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_en", 32'(mem_en), 32'd0);
    tick();                                   // cycle 5, restarted ISSUE
    check("restart_en",  32'(mem_en),  32'd1);
    check("restart_sel", 32'(mem_sel), 32'd0);
    tick(); tick();                           // cycle 7
    check("restart_ack_c7", 32'(if_ack), 32'd0);
    tick();                                   // cycle 8
    check("restart_ack_c8", 32'(if_ack), 32'd1);
    check("restart_rdata", rdata, 32'hCAFEF00D);
    if_req = 1'b0;
    wait_idle();

    // MEM_LAT=1 build, DM read.
    mem_rdata1 = 32'hA5A5A5A5;
    dm_req1 = 1'b1;                           // cycle 0
    tick();                                   // cycle 1
    check("lat1_en_c1",  32'(mem_en1),  32'd1);
    check("lat1_sel_c1", 32'(mem_sel1), 32'd1);
    tick();                                   // cycle 2
    check("lat1_ack_c2", 32'(dm_ack1), 32'd0);
    tick();                                   // cycle 3
    check("lat1_ack_c3", 32'(dm_ack1), 32'd1);
    check("lat1_rdata",  rdata1, 32'hA5A5A5A5);
    dm_req1 = 1'b0;
    tick();                                   // cycle 4
    check("lat1_busy_c4", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
